instr_fetch_unit: RTL and testbench

//  Fetch stage placed directly upstream of the instruction ROM's consumer. Owns the PC and drives the ROM address bus.
//  The ROM read is asynchronous. Each word is captured into an output register and split into opcode/operand.
//  The register is handed downstream over a valid/ready handshake. Handles start, redirect and halt.

---
 rtl/isa_pkg.sv | 26 ++
 rtl/instr_fetch_unit.sv | 128 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/isa_pkg.sv
// ISA definitions for the fetch stage: instruction field widths, opcodes and fetch FSM states.
package isa_pkg;

    localparam int unsigned ISA_DATA_W = 8;
    localparam int unsigned OPC_W      = 3;
    localparam int unsigned OPR_W      = ISA_DATA_W - OPC_W;

    typedef enum logic [OPC_W-1:0] {
        OPC_ADD  = 3'd0,
        OPC_SUB  = 3'd1,
        OPC_AND  = 3'd2,
        OPC_OR   = 3'd3,
        OPC_NOT  = 3'd4,
        OPC_XOR  = 3'd5,
        OPC_XNOR = 3'd6,
        OPC_HALT = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_RUN        = 2'd1,
        ST_HALT_DRAIN = 2'd2,
        ST_STOP       = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads the asynchronous instruction ROM and hands split
// opcode/operand words downstream over valid/ready, with start, redirect and halt handling.
module instr_fetch_unit
    import isa_pkg::*;
#(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = ISA_DATA_W,
    parameter int unsigned PROG_LEN = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OPC_W-1:0]  out_opcode,
    output logic [OPR_W-1:0]  out_operand,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              redir_valid,
    input  logic [ADDR_W-1:0] redir_pc,
    output logic              halted,
    output logic              fault
);

    localparam logic [ADDR_W-1:0] END_PC = ADDR_W'(PROG_LEN);

    fetch_state_e      state_q;
    fetch_state_e      state_nxt;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_nxt;
    logic              halted_nxt;
    logic              fault_nxt;
    logic              capture_c;
    logic              flush_c;
    logic              accept_c;
    logic [OPC_W-1:0]  opc_c;

    assign opc_c     = imem_data[DATA_W-1 -: OPC_W];
    assign accept_c  = out_valid && out_ready;
    assign imem_addr = pc_q;

    // Next-state, PC and capture/flush decisions, in redirect > end-of-program > capture > stall order
    always_comb begin
        state_nxt  = state_q;
        pc_nxt     = pc_q;
        halted_nxt = halted;
        fault_nxt  = fault;
        capture_c  = 1'b0;
        flush_c    = 1'b0;
        case (state_q)
            ST_IDLE, ST_STOP: begin
                if (start) begin
                    state_nxt  = ST_RUN;
                    pc_nxt     = '0;
                    halted_nxt = 1'b0;
                end
            end
            ST_RUN, ST_HALT_DRAIN: begin
                if (redir_valid) begin
                    flush_c = 1'b1;
                    if (redir_pc < END_PC) begin
                        pc_nxt    = redir_pc;
                        state_nxt = ST_RUN;
                    end else begin
                        fault_nxt  = 1'b1;
                        halted_nxt = 1'b1;
                        state_nxt  = ST_STOP;
                    end
                end else if (state_q == ST_HALT_DRAIN) begin
                    if (accept_c) begin
                        halted_nxt = 1'b1;
                        state_nxt  = ST_STOP;
                    end
                end else if (pc_q == END_PC) begin
                    // Wait for the last word to drain before reporting halt
                    if (!out_valid) begin
                        halted_nxt = 1'b1;
                        state_nxt  = ST_STOP;
                    end
                end else if (!out_valid || out_ready) begin
                    capture_c = 1'b1;
                    if (opc_c == OPC_HALT) begin
                        state_nxt = ST_HALT_DRAIN;
                    end else begin
                        pc_nxt = pc_q + ADDR_W'(1);
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // PC and FSM state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            halted  <= 1'b0;
            fault   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            pc_q    <= pc_nxt;
            halted  <= halted_nxt;
            fault   <= fault_nxt;
        end
    end

    // Output register: flush beats capture, capture beats a plain accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_opcode  <= '0;
            out_operand <= '0;
            out_pc      <= '0;
        end else if (flush_c) begin
            out_valid <= 1'b0;
        end else if (capture_c) begin
            out_valid   <= 1'b1;
            out_opcode  <= opc_c;
            out_operand <= imem_data[OPR_W-1:0];
            out_pc      <= pc_q;
        end else if (accept_c) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: streaming, stall, HALT, run-off-end, redirect/fault, async reset.
module tb_instr_fetch_unit;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [4:0] imem_addr;
    logic [7:0] imem_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_opcode;
    logic [4:0] out_operand;
    logic [4:0] out_pc;
    logic       redir_valid;
    logic [4:0] redir_pc;
    logic       halted;
    logic       fault;

    logic [7:0] rom [32];
    int checks;
    int failures;

    assign imem_data = rom[imem_addr];

    instr_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_opcode  (out_opcode),
        .out_operand (out_operand),
        .out_pc      (out_pc),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .halted      (halted),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input int pc, input int opc, input int opr);
        chk({tag, "_valid"},   32'(out_valid),   32'd1);
        chk({tag, "_pc"},      32'(out_pc),      32'(pc));
        chk({tag, "_opcode"},  32'(out_opcode),  32'(opc));
        chk({tag, "_operand"}, 32'(out_operand), 32'(opr));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        out_ready   = 1'b1;
        redir_valid = 1'b0;
        redir_pc    = '0;
        for (int i = 0; i < 32; i++) rom[i] = 8'h1F;
        for (int i = 0; i < 6; i++) rom[i] = {3'(i), 5'(i)};
        rom[6] = 8'hE0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid",  32'(out_valid), 32'd0);
        chk("rst_pc",     32'(out_pc),    32'd0);
        chk("rst_addr",   32'(imem_addr), 32'd0);
        chk("rst_halted", 32'(halted),    32'd0);
        chk("rst_fault",  32'(fault),     32'd0);
        rst_n = 1'b1;

        // Redirect while IDLE is ignored
        redir_valid = 1'b1;
        redir_pc    = 5'd20;
        @(negedge clk);
        redir_valid = 1'b0;
        chk("idle_redir_fault", 32'(fault),     32'd0);
        chk("idle_redir_addr",  32'(imem_addr), 32'd0);

        // 1) Streaming at one word per cycle
        pulse_start();
        chk("run_entry_valid", 32'(out_valid), 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk_word("stream", k, k, k);
            chk("stream_addr", 32'(imem_addr), 32'(k + 1));
        end

        // 2) Stall three cycles on the word from pc 4
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_word("stall", 4, 4, 4);
            chk("stall_addr", 32'(imem_addr), 32'd5);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk_word("resume", 5, 5, 5);

        // 3) HALT word at pc 6 is presented, then fetch stops
        @(negedge clk);
        chk_word("halt", 6, 7, 0);
        chk("halt_addr_frozen", 32'(imem_addr), 32'd6);
        @(negedge clk);
        chk("halt_valid_drop", 32'(out_valid), 32'd0);
        chk("halt_halted",     32'(halted),    32'd1);
        @(negedge clk);
        chk("halt_no_pc7",     32'(out_valid), 32'd0);

        // 4) Program without HALT runs off the end after pc 12
        for (int i = 0; i < 32; i++) rom[i] = {3'(i % 7), 5'(i)};
        pulse_start();
        chk("restart_halted", 32'(halted),    32'd0);
        chk("restart_addr",   32'(imem_addr), 32'd0);
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            chk_word("full", k, k % 7, k);
        end
        @(negedge clk);
        chk("end_valid",  32'(out_valid), 32'd0);
        @(negedge clk);
        chk("end_halted", 32'(halted),    32'd1);
        chk("end_valid2", 32'(out_valid), 32'd0);
        chk("end_addr",   32'(imem_addr), 32'd13);

        // 5) Redirect while stalled flushes, then fetch resumes at pc 9
        pulse_start();
        @(negedge clk);
        chk_word("pre_redir", 0, 0, 0);
        out_ready   = 1'b0;
        redir_valid = 1'b1;
        redir_pc    = 5'd9;
        @(negedge clk);
        redir_valid = 1'b0;
        out_ready   = 1'b1;
        chk("redir_flush", 32'(out_valid), 32'd0);
        chk("redir_addr",  32'(imem_addr), 32'd9);
        @(negedge clk);
        chk_word("redir_word", 9, 2, 9);

        // Out-of-range redirect with a simultaneous accept faults and stops
        redir_valid = 1'b1;
        redir_pc    = 5'd20;
        @(negedge clk);
        redir_valid = 1'b0;
        chk("fault_set",    32'(fault),     32'd1);
        chk("fault_halted", 32'(halted),    32'd1);
        chk("fault_valid",  32'(out_valid), 32'd0);
        @(negedge clk);
        chk("fault_stopped", 32'(out_valid), 32'd0);
        pulse_start();
        chk("fault_sticky",     32'(fault),  32'd1);
        chk("fault_restart_hl", 32'(halted), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_word("post_fault", k, k % 7, k);
        end

        // 6) Asynchronous reset between clock edges
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid",   32'(out_valid),   32'd0);
        chk("arst_pc",      32'(out_pc),      32'd0);
        chk("arst_opcode",  32'(out_opcode),  32'd0);
        chk("arst_operand", 32'(out_operand), 32'd0);
        chk("arst_addr",    32'(imem_addr),   32'd0);
        chk("arst_fault",   32'(fault),       32'd0);
        chk("arst_halted",  32'(halted),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        @(negedge clk);
        chk_word("arst_restart0", 0, 0, 0);
        @(negedge clk);
        chk_word("arst_restart1", 1, 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
